// File: rtl/task_graph_pkg.sv
// rtl/task_graph_pkg.sv - shared task-graph constants and streamer state encoding
package task_graph_pkg;

    localparam int TG_NUM_V  = 4;
    localparam int TG_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        GAP_PRE,
        END,
        GAP_POST,
        FIN
    } tg_state_e;

endpackage

// File: rtl/task_graph_regfile.sv
// rtl/task_graph_regfile.sv - NUM_V x NUM_V edge-weight store, one write port, one async read port
module task_graph_regfile #(
    parameter int NUM_V  = 4,
    parameter int DATA_W = 32,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              we_i,
    input  logic [AW-1:0]     wr_row_i,
    input  logic [AW-1:0]     wr_col_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_row_i,
    input  logic [AW-1:0]     rd_col_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int NE = NUM_V * NUM_V;
    localparam int EW = (NE > 1) ? $clog2(NE) : 1;

    logic [DATA_W-1:0] mem_q [NE];
    logic [EW-1:0]     widx;
    logic [EW-1:0]     ridx;

    assign widx      = EW'(wr_row_i) * EW'(NUM_V) + EW'(wr_col_i);
    assign ridx      = EW'(rd_row_i) * EW'(NUM_V) + EW'(rd_col_i);
    assign rd_data_o = mem_q[ridx];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[widx] <= wr_data_i;
        end
    end

endmodule

// File: rtl/task_graph_streamer.sv
// rtl/task_graph_streamer.sv - streams a stored task-graph matrix row-major into task_mapper
module task_graph_streamer
    import task_graph_pkg::*;
#(
    parameter int NUM_V  = TG_NUM_V,
    parameter int DATA_W = TG_DATA_W,
    parameter int IDX_W  = 32,
    parameter int DWELL  = 2,
    parameter int APP_W  = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_row,
    input  logic [IDX_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [APP_W-1:0]  app_count,
    input  logic              hold,
    output logic [DATA_W-1:0] task_array,
    output logic              root_task,
    output logic [IDX_W-1:0]  row,
    output logic [IDX_W-1:0]  col,
    output logic              app_end,
    output logic              busy,
    output logic              done
);

    localparam int AW   = (NUM_V > 1) ? $clog2(NUM_V) : 1;
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [AW-1:0]   LAST_IDX  = AW'(NUM_V - 1);
    localparam logic [DW_W-1:0] LAST_DWEL = DW_W'(DWELL - 1);

    tg_state_e         state_q, state_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [AW-1:0]     row_q, row_d, col_q, col_d;
    logic [APP_W-1:0]  apps_q, apps_d;
    logic              found_q, found_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              root_q, root_d;
    logic              app_end_q, app_end_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              wr_ok;
    logic              load_entry, new_app, found_base;
    logic [DATA_W-1:0] rf_rdata, rd_data;

    assign wr_ok = wr_en && (state_q == IDLE) &&
                   (wr_row < IDX_W'(NUM_V)) && (wr_col < IDX_W'(NUM_V));

    task_graph_regfile #(
        .NUM_V (NUM_V),
        .DATA_W(DATA_W),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_b    (rst_b),
        .we_i     (wr_ok),
        .wr_row_i (wr_row[AW-1:0]),
        .wr_col_i (wr_col[AW-1:0]),
        .wr_data_i(wr_data),
        .rd_row_i (row_d),
        .rd_col_i (col_d),
        .rd_data_o(rf_rdata)
    );

    // A write coinciding with start must be seen by the first entry fetched.
    assign rd_data = (wr_ok && wr_row[AW-1:0] == row_d && wr_col[AW-1:0] == col_d)
                     ? wr_data : rf_rdata;

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        row_d      = row_q;
        col_d      = col_q;
        apps_d     = apps_q;
        found_d    = found_q;
        data_d     = data_q;
        root_d     = root_q;
        app_end_d  = app_end_q;
        busy_d     = busy_q;
        done_d     = done_q;
        load_entry = 1'b0;
        new_app    = 1'b0;

        if (!(hold && state_q != IDLE && state_q != FIN)) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (app_count == '0) begin
                            state_d = FIN;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = EMIT;
                            apps_d     = app_count;
                            row_d      = '0;
                            col_d      = '0;
                            dwell_d    = '0;
                            busy_d     = 1'b1;
                            load_entry = 1'b1;
                            new_app    = 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (dwell_q != LAST_DWEL) begin
                        dwell_d = dwell_q + DW_W'(1);
                    end else if (row_q == LAST_IDX && col_q == LAST_IDX) begin
                        state_d = GAP_PRE;
                        root_d  = 1'b0;
                    end else begin
                        dwell_d    = '0;
                        load_entry = 1'b1;
                        if (col_q == LAST_IDX) begin
                            col_d = '0;
                            row_d = row_q + AW'(1);
                        end else begin
                            col_d = col_q + AW'(1);
                        end
                    end
                end
                GAP_PRE: begin
                    state_d   = END;
                    app_end_d = 1'b1;
                end
                END: begin
                    state_d   = GAP_POST;
                    app_end_d = 1'b0;
                end
                GAP_POST: begin
                    if (apps_q == APP_W'(1)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        data_d  = '0;
                        row_d   = '0;
                        col_d   = '0;
                        root_d  = 1'b0;
                    end else begin
                        state_d    = EMIT;
                        apps_d     = apps_q - APP_W'(1);
                        row_d      = '0;
                        col_d      = '0;
                        dwell_d    = '0;
                        load_entry = 1'b1;
                        new_app    = 1'b1;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end

        found_base = new_app ? 1'b0 : found_q;
        if (load_entry) begin
            data_d  = rd_data;
            root_d  = (rd_data != '0) && !found_base;
            found_d = found_base || (rd_data != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            dwell_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            apps_q    <= '0;
            found_q   <= 1'b0;
            data_q    <= '0;
            root_q    <= 1'b0;
            app_end_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            row_q     <= row_d;
            col_q     <= col_d;
            apps_q    <= apps_d;
            found_q   <= found_d;
            data_q    <= data_d;
            root_q    <= root_d;
            app_end_q <= app_end_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign task_array = data_q;
    assign root_task  = root_q;
    assign row        = IDX_W'(row_q);
    assign col        = IDX_W'(col_q);
    assign app_end    = app_end_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
